// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the button debounce block.
//   - state_t             : debounce FSM state encoding
//   - DEBOUNCE_CYCLES_DEF : default number of stable synchronized samples
//   - PRESS_CNT_W         : width of the accepted-press counter
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PRESS_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level input.
//   Ports:
//     clk : sampling clock
//     rst : synchronous active-low reset, clears both flops
//     d   : asynchronous input
//     q   : synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse
//   Debounces a raw mechanical button and produces a clean level plus
//   one-cycle edge pulses and a wrapping count of accepted presses.
//   Ports:
//     clk         : clock, all state changes on rising edge
//     rst         : synchronous active-low reset
//     btn_in      : raw asynchronous bouncing button level
//     level       : debounced level (registered)
//     rise_pulse  : one cycle on each accepted 0->1 (toggle enable downstream)
//     fall_pulse  : one cycle on each accepted 1->0
//     press_count : accepted presses, wraps 255 -> 0 (registered)
//
//   state     | meaning
//   ----------+-------------------------------------------
//   IDLE      | stable low
//   WAIT_HIGH | input high, counting stable high samples
//   PRESSED   | stable high
//   WAIT_LOW  | input low, counting stable low samples
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  output logic                   level,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Terminal count: the sample that matches this count is the
  // DEBOUNCE_CYCLES+1-th consecutive stable one (entry sample + count).
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   btn_sync;
  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   level_nxt;
  logic                   rise_nxt;
  logic                   fall_nxt;
  logic [PRESS_CNT_W-1:0] press_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // State and output registers; outputs come straight from flops so there
  // is no combinational path from btn_in to any port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      level       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      level       <= level_nxt;
      rise_pulse  <= rise_nxt;
      fall_pulse  <= fall_nxt;
      press_count <= press_nxt;
    end
  end

  // Next state and debounce counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the accepting transitions only. A pulse always
  // lands the FSM in a stable state, which cannot accept on the following
  // cycle, so pulses can never be back-to-back or overlap.
  always_comb begin
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    press_nxt = press_count;
    if (state == WAIT_HIGH && state_nxt == PRESSED) begin
      level_nxt = 1'b1;
      rise_nxt  = 1'b1;
      press_nxt = press_count + PRESS_CNT_W'(1);
    end
    if (state == WAIT_LOW && state_nxt == IDLE) begin
      level_nxt = 1'b0;
      fall_nxt  = 1'b1;
    end
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter SHALL be DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter SHALL be CNT_WIDTH, default 16, the debounce counter width; it must satisfy 2**CNT_WIDTH >= DEBOUNCE_CYCLES.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-005 Port btn_in SHALL be input, 1 bit: raw asynchronous, bouncing button level.
REQ-006 Port level SHALL be output, 1 bit: the debounced button level, registered.
REQ-007 Port rise_pulse SHALL be output, 1 bit: one-cycle pulse on each accepted 0->1 change; this is the toggle-enable for the downstream T flip-flop d input.
REQ-008 Port fall_pulse SHALL be output, 1 bit: one-cycle pulse on each accepted 1->0 change.
REQ-009 Port press_count SHALL be output, 8 bits: count of accepted presses, registered.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer; only the second flop output (btn_sync) is used by the FSM.
REQ-011 The FSM SHALL have four states: IDLE (stable low), WAIT_HIGH, PRESSED (stable high), WAIT_LOW.
REQ-012 IDLE: if btn_sync=1, go to WAIT_HIGH with cnt cleared to 0; otherwise stay in IDLE.
REQ-013 WAIT_HIGH, btn_sync=0: return to IDLE, clear cnt, emit no pulse.
REQ-014 WAIT_HIGH, btn_sync=1 and cnt=DEBOUNCE_CYCLES-1: go to PRESSED, set level=1, assert rise_pulse for exactly one cycle, and increment press_count.
REQ-015 WAIT_HIGH, btn_sync=1 otherwise: increment cnt.
REQ-016 PRESSED, WAIT_LOW and the 1->0 acceptance SHALL mirror REQ-012..015 with the polarity inverted; acceptance clears level and asserts fall_pulse for one cycle; press_count is unchanged.
REQ-017 Latency: with btn_in stable from before rising edge E0, level and the pulse SHALL change on edge E0+DEBOUNCE_CYCLES+2 (edge E6 for the default), never earlier.
REQ-018 Any glitch shorter than DEBOUNCE_CYCLES+1 synchronized cycles SHALL produce no change on level and no pulse.
REQ-019 rise_pulse and fall_pulse SHALL never be asserted together; neither SHALL be asserted for two consecutive cycles.
REQ-020 press_count SHALL wrap from 255 to 0 on the next accepted press, with no saturation and no flag.
REQ-021 cnt SHALL never exceed DEBOUNCE_CYCLES-1; it is cleared on every entry to a WAIT state and on every return to a stable state.

Reset
REQ-022 While rst=0 at a rising edge, the following SHALL be cleared on that edge: both synchronizer flops, cnt, level, rise_pulse, fall_pulse, press_count; the state SHALL become IDLE.
REQ-023 Reset mid-operation (any state) SHALL take effect on the next edge with no fall_pulse generated, even if level was 1.
REQ-024 If btn_in is held high across reset release, the block SHALL perform a full debounce and then emit exactly one rise_pulse, per REQ-017.

Structure
REQ-025 The shared package debounce_pkg SHALL hold the state enumeration typedef and the DEBOUNCE_CYCLES default constant.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rst, d, q; it is reused for other asynchronous inputs.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from btn_in to any output.

Verification
REQ-028 Clean press, DEBOUNCE_CYCLES=4: btn_in rises before E0 and is held -> level=1 and rise_pulse=1 after E6 only; press_count=1.
REQ-029 Bounce: btn_in toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during the bounce; exactly one rise_pulse, 7 edges after the final 0->1.
REQ-030 Release: from PRESSED, btn_in drops and is held -> fall_pulse for one cycle at E0+6; level=0; press_count unchanged.
REQ-031 Wrap: 256 clean press/release pairs -> press_count counts 1..255, then reads 0; 256 rise_pulses and 256 fall_pulses in total.
REQ-032 Reset mid-press: rst=0 while in PRESSED -> level=0 on the next edge, no fall_pulse, press_count=0; with btn_in still high after release, one rise_pulse follows after 7 edges.
REQ-033 Short glitch: btn_in high for 3 cycles only -> level stays 0 and no pulses occur.
